// File: rtl/host_mem_if.sv
// Host-side request/response bundle of the SDRAM controller: write port, read port and busy.
interface host_mem_if #(
  parameter int HOST_ADDR_WIDTH = 24,
  parameter int DATA_WIDTH      = 16
);
  logic [HOST_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic                       wr_enable;
  logic [HOST_ADDR_WIDTH-1:0] rd_addr;
  logic                       rd_enable;
  logic [DATA_WIDTH-1:0]      rd_data;
  logic                       rd_ready;
  logic                       busy;

  modport master (
    output wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    input  rd_data, rd_ready, busy
  );

  modport slave (
    input  wr_addr, wr_data, wr_enable, rd_addr, rd_enable,
    output rd_data, rd_ready, busy
  );
endinterface

// File: rtl/host_mem_responder.sv
// Stand-in for sdram_controller's host side: a small word array with fixed write/read latency.
// Define HOST_RESP_REFRESH_EN to add periodic refresh stalls on busy.
module host_mem_responder #(
  parameter int ADDR_WIDTH      = 4,
  parameter int DATA_WIDTH      = 16,
  parameter int HOST_ADDR_WIDTH = 24,
  parameter int WR_LATENCY      = 3,
  parameter int RD_LATENCY      = 5,
  parameter int REFRESH_PERIOD  = 64,
  parameter int REFRESH_CYCLES  = 4
) (
  input  logic      clk,
  input  logic      rst,
  host_mem_if.slave host
);

  localparam int MAX_RW = (WR_LATENCY > RD_LATENCY) ? WR_LATENCY : RD_LATENCY;
`ifdef HOST_RESP_REFRESH_EN
  localparam int MAX_LAT = (MAX_RW > REFRESH_CYCLES) ? MAX_RW : REFRESH_CYCLES;
  localparam int REF_W   = $clog2(REFRESH_PERIOD) + 1;
`else
  localparam int MAX_LAT = MAX_RW;
`endif
  localparam int CNT_W = $clog2(MAX_LAT) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    READY
`ifdef HOST_RESP_REFRESH_EN
    , REFRESH
`endif
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    busy_q;
  logic                    busy;
  logic                    accept;
  logic                    accept_wr;
  logic                    accept_rd;
  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0]   rd_hold_p0;
  logic [DATA_WIDTH-1:0]   rd_data_p1;
  logic                    rd_vld_p1;
  logic [ADDR_WIDTH-1:0]   wr_idx;
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    addr_unused;

  // Upper host address bits alias away.
  assign wr_idx      = host.wr_addr[ADDR_WIDTH-1:0];
  assign rd_idx      = host.rd_addr[ADDR_WIDTH-1:0];
  assign addr_unused = ^{host.wr_addr[HOST_ADDR_WIDTH-1:ADDR_WIDTH],
                         host.rd_addr[HOST_ADDR_WIDTH-1:ADDR_WIDTH]};

`ifdef HOST_RESP_REFRESH_EN
  logic [REF_W-1:0] ref_cnt;
  logic             refresh_pending;
  logic             ref_expire;
  logic             pend_eff;
  logic             pend_clr;

  assign ref_expire = (ref_cnt == REF_W'(REFRESH_PERIOD - 1));
  assign pend_eff   = refresh_pending | ref_expire;
  assign busy       = busy_q | refresh_pending;

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt         <= '0;
      refresh_pending <= 1'b0;
    end else begin
      if (ref_expire) ref_cnt <= '0;
      else            ref_cnt <= ref_cnt + REF_W'(1);
      if (pend_clr)   refresh_pending <= 1'b0;
      if (ref_expire) refresh_pending <= 1'b1;
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = (REFRESH_PERIOD > 0) ^ (REFRESH_CYCLES > 0);
  assign busy       = busy_q;
`endif

  assign accept = !rst && !busy && (host.wr_enable || host.rd_enable);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept_wr = 1'b0;
    accept_rd = 1'b0;
`ifdef HOST_RESP_REFRESH_EN
    pend_clr  = 1'b0;
`endif
    case (state)
      IDLE, READY: begin
        if (accept && host.wr_enable) begin
          state_nxt = WRITE;
          cnt_nxt   = CNT_W'(WR_LATENCY - 1);
          accept_wr = 1'b1;
        end else if (accept) begin
          state_nxt = READ;
          cnt_nxt   = CNT_W'(RD_LATENCY - 1);
          accept_rd = 1'b1;
        end
`ifdef HOST_RESP_REFRESH_EN
        else if (pend_eff) begin
          state_nxt = REFRESH;
          cnt_nxt   = CNT_W'(REFRESH_CYCLES - 1);
        end
`endif
        else begin
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      READ: begin
        if (cnt == '0) state_nxt = READY;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
`ifdef HOST_RESP_REFRESH_EN
      REFRESH: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          pend_clr  = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // p0: array access on the acceptance edge; writes commit here and survive a later reset.
  always_ff @(posedge clk) begin
    if (accept_wr) mem[wr_idx] <= host.wr_data;
    if (accept_rd) rd_hold_p0  <= mem[rd_idx];
  end

  // p1: registered FSM state, busy and read-completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      busy_q     <= 1'b0;
      rd_vld_p1  <= 1'b0;
      rd_data_p1 <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy_q     <= (state_nxt == WRITE) || (state_nxt == READ)
`ifdef HOST_RESP_REFRESH_EN
                    || (state_nxt == REFRESH)
`endif
                    ;
      rd_vld_p1  <= (state_nxt == READY);
      if (state_nxt == READY) rd_data_p1 <= rd_hold_p0;
    end
  end

  assign host.rd_data  = rd_data_p1;
  assign host.rd_ready = rd_vld_p1;
  assign host.busy     = busy;

endmodule

// File: tb/tb_host_mem_responder.sv
// Directed bench for host_mem_responder: reset, write/read latency, collision, aliasing, ignored and back-to-back requests.
module tb_host_mem_responder;
  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int HAW = 24;
  localparam int WRL = 3;
  localparam int RDL = 5;
`ifdef HOST_RESP_REFRESH_EN
  localparam int RP  = 16;
`else
  localparam int RP  = 64;
`endif
  localparam int RC  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  host_mem_if #(.HOST_ADDR_WIDTH(HAW), .DATA_WIDTH(DW)) bus ();

  host_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .HOST_ADDR_WIDTH(HAW),
    .WR_LATENCY(WRL), .RD_LATENCY(RDL),
    .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [HAW-1:0] addr, output bit got);
    bus.rd_addr   = addr;
    bus.rd_enable = 1'b1;
    step();
    bus.rd_enable = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.rd_ready === 1'b1) begin
        got = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bit got;
    rst = 1'b1;
    bus.wr_enable = 1'b1;
    bus.rd_enable = 1'b1;
    bus.wr_addr   = 24'h7;
    bus.wr_data   = 16'hDEAD;
    bus.rd_addr   = 24'h7;
    for (int i = 0; i < 2; i++) begin
      step();
      checks += 3;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_ready: got %b want 0", bus.rd_ready); end
      if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL reset_rd_data: got %h want 0000", bus.rd_data); end
    end
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    rst = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", bus.busy); end
    do_read(24'h7, got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL reset_nowrite_ready: no rd_ready within 20 cycles"); end
    if (bus.rd_data === 16'hDEAD) begin errors++; $display("FAIL reset_nowrite_data: got %h, write during reset must not commit", bus.rd_data); end
    step();
  endtask

  task automatic test_write_read();
    int n;
    bus.wr_addr   = 24'h3;
    bus.wr_data   = 16'hA5A5;
    bus.wr_enable = 1'b1;
    step();
    bus.wr_enable = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (n != WRL) begin errors++; $display("FAIL write_busy_len: got %0d want %0d", n, WRL); end
    bus.rd_addr   = 24'h3;
    bus.rd_enable = 1'b1;
    step();
    bus.rd_enable = 1'b0;
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin n++; step(); end
    checks += 4;
    if (n != RDL) begin errors++; $display("FAIL read_busy_len: got %0d want %0d", n, RDL); end
    if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL read_ready: got %b want 1", bus.rd_ready); end
    if (bus.rd_data !== 16'hA5A5) begin errors++; $display("FAIL read_data: got %h want a5a5", bus.rd_data); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL read_ready_busy: got %b want 0", bus.busy); end
    step();
    checks += 2;
    if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL ready_pulse_width: got %b want 0", bus.rd_ready); end
    if (bus.rd_data !== 16'hA5A5) begin errors++; $display("FAIL read_data_hold: got %h want a5a5", bus.rd_data); end
  endtask

  task automatic test_collision();
    int seen;
    bit got;
    bus.wr_addr   = 24'h000015;
    bus.rd_addr   = 24'h000015;
    bus.wr_data   = 16'h1234;
    bus.wr_enable = 1'b1;
    bus.rd_enable = 1'b1;
    step();
    bus.wr_enable = 1'b0;
    bus.rd_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rd_ready === 1'b1) seen++;
      step();
    end
    checks += 2;
    if (seen != 0) begin errors++; $display("FAIL collision_no_read: got %0d rd_ready pulses want 0", seen); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL collision_idle: busy=%b want 0", bus.busy); end
    do_read(24'h000005, got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL alias_ready: no rd_ready within 20 cycles"); end
    if (bus.rd_data !== 16'h1234) begin errors++; $display("FAIL alias_data: got %h want 1234", bus.rd_data); end
    step();
  endtask

  task automatic test_ignored_and_back_to_back();
    int seen;
    int n;
    bus.wr_addr   = 24'h1;
    bus.wr_data   = 16'h0101;
    bus.wr_enable = 1'b1;
    step();
    bus.wr_enable = 1'b0;
    bus.rd_addr   = 24'h1;
    bus.rd_enable = 1'b1;
    step();
    bus.rd_enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.rd_ready === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL ignored_read: got %0d rd_ready pulses want 0", seen); end
    bus.rd_addr   = 24'h3;
    bus.rd_enable = 1'b1;
    step();
    n = 0;
    while (bus.rd_ready !== 1'b1 && n < 20) begin n++; step(); end
    checks++;
    if (bus.rd_data !== 16'hA5A5) begin errors++; $display("FAIL b2b_first_data: got %h want a5a5", bus.rd_data); end
    bus.rd_addr = 24'h1;
    step();
    bus.rd_enable = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept_in_ready: busy=%b want 1", bus.busy); end
    n = 0;
    while (bus.busy === 1'b1 && n < 20) begin n++; step(); end
    checks += 3;
    if (n != RDL) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", n, RDL); end
    if (bus.rd_ready !== 1'b1) begin errors++; $display("FAIL b2b_second_ready: got %b want 1", bus.rd_ready); end
    if (bus.rd_data !== 16'h0101) begin errors++; $display("FAIL b2b_second_data: got %h want 0101", bus.rd_data); end
    step();
  endtask

  task automatic test_reset_mid_read();
    int seen;
    bit got;
    bus.rd_addr   = 24'h3;
    bus.rd_enable = 1'b1;
    step();
    bus.rd_enable = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    if (bus.rd_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", bus.rd_ready); end
    if (bus.rd_data !== 16'h0) begin errors++; $display("FAIL midrst_data: got %h want 0000", bus.rd_data); end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rd_ready === 1'b1) seen++;
      step();
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midrst_no_ready: got %0d pulses want 0", seen); end
    do_read(24'h3, got);
    checks += 2;
    if (!got) begin errors++; $display("FAIL midrst_reread_ready: no rd_ready within 20 cycles"); end
    if (bus.rd_data !== 16'hA5A5) begin errors++; $display("FAIL midrst_reread_data: got %h want a5a5", bus.rd_data); end
    step();
  endtask

`ifdef HOST_RESP_REFRESH_EN
  task automatic test_refresh();
    int m;
    int k;
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.wr_addr   = 24'h3;
    bus.wr_data   = 16'hA5A5;
    bus.wr_enable = 1'b1;
    step();
    bus.wr_enable = 1'b0;
    for (int i = 2; i <= 15; i++) step();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL refresh_pre_idle: busy=%b want 0", bus.busy); end
    step();
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL refresh_start: busy=%b want 1", bus.busy); end
    bus.rd_addr   = 24'h3;
    bus.rd_enable = 1'b1;
    m = 1;
    step();
    while (bus.busy === 1'b1 && m < 20) begin m++; step(); end
    checks++;
    if (m != RC) begin errors++; $display("FAIL refresh_len: got %0d want %0d", m, RC); end
    step();
    bus.rd_enable = 1'b0;
    k = 1;
    while (bus.rd_ready !== 1'b1 && k < 20) begin step(); k++; end
    checks += 2;
    if (k != RDL + 1) begin errors++; $display("FAIL refresh_read_latency: got %0d want %0d", k, RDL + 1); end
    if (bus.rd_data !== 16'hA5A5) begin errors++; $display("FAIL refresh_read_data: got %h want a5a5", bus.rd_data); end
  endtask
`endif

  initial begin
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.wr_enable = 1'b0;
    bus.rd_addr   = '0;
    bus.rd_enable = 1'b0;
    test_reset();
`ifdef HOST_RESP_REFRESH_EN
    test_refresh();
`else
    test_write_read();
    test_collision();
    test_ignored_and_back_to_back();
    test_reset_mid_read();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/host_mem_responder.md
# host_mem_responder

Behavioural responder for the SDRAM controller host interface: wr_addr/wr_data/wr_enable, rd_addr/rd_enable/rd_data/rd_ready, busy. It answers tester_ctrl requests from a small on-chip word array with programmable write/read latency, so the tester and its LED status path can be brought up on simulation or FPGA without an SDRAM device or memory model. It is a drop-in substitute for sdram_controller on the host side only; it has no SDRAM pins.

## Interface
- ADDR_WIDTH, 4: array depth is 2^ADDR_WIDTH words; only wr_addr/rd_addr[ADDR_WIDTH-1:0] are decoded.
- DATA_WIDTH, 16: word width.
- HOST_ADDR_WIDTH, 24: width of the host address ports.
- WR_LATENCY, 3: busy cycles per write, ≥1.
- RD_LATENCY, 5: busy cycles per read before rd_ready, ≥1.
- REFRESH_PERIOD, 64: cycles between refresh stalls; used only with HOST_RESP_REFRESH_EN.
- REFRESH_CYCLES, 4: busy cycles per refresh stall, ≥1; used only with HOST_RESP_REFRESH_EN.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- wr_addr  in  HOST_ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_enable  in  1  write request; held by the initiator until accepted.
- rd_addr  in  HOST_ADDR_WIDTH  read address.
- rd_enable  in  1  read request; held by the initiator until accepted.
- rd_data  out  DATA_WIDTH  read data; valid when rd_ready=1 and held until the next read completes.
- rd_ready  out  1  single-cycle read-completion pulse.
- busy  out  1  1 means requests are not accepted this cycle.

## Operation
- States: IDLE, WRITE, READ, READY, plus REFRESH when the macro is defined.
- Acceptance occurs on an edge where busy=0 and (wr_enable or rd_enable) is 1.
- If both enables are high, the write wins. The read is not queued; the initiator must keep rd_enable high.
- Write: the array word is updated on the acceptance edge. The FSM goes IDLE→WRITE, holds there WR_LATENCY cycles, then returns to IDLE.
- Read: the array word is captured into an internal holding register on the acceptance edge. The FSM goes IDLE→READ and holds there RD_LATENCY cycles. It then enters READY for one cycle, with rd_ready=1, rd_data=captured word and busy=0, and returns to IDLE.
- A new request is accepted in the READY cycle.
- Enables presented while busy=1 are ignored. Nothing is latched or queued.
- Address bits at and above ADDR_WIDTH are ignored, so addresses alias modulo 2^ADDR_WIDTH.
- Latency counter: down-counter loaded with latency-1 on state entry; the state exits when the counter reaches 0. Counter width is $clog2 of the largest latency parameter plus 1.
- Reset behaviour: busy=0, rd_ready=0, rd_data=0, state IDLE, counters cleared. Array contents are not reset, and a read of an unwritten word returns X in simulation.
- Reset asserted mid-operation: the operation is abandoned and no rd_ready is produced. A write already committed on its acceptance edge stays in the array.

## Timing
- Acceptance edge = cycle 0.
- Write: busy=1 in cycles 1..WR_LATENCY; busy=0 in cycle WR_LATENCY+1.
- Read: busy=1 in cycles 1..RD_LATENCY; rd_ready=1 and busy=0 in cycle RD_LATENCY+1.
- Throughput: one write per WR_LATENCY+1 cycles; one read per RD_LATENCY+1 cycles.
- busy is registered, except the pending-refresh term described under Configuration.
- rd_ready and rd_data are registered.

## Configuration
- HOST_RESP_REFRESH_EN defined:
  - A free-running counter counts REFRESH_PERIOD cycles from reset release. On expiry it sets refresh_pending and restarts.
  - busy = (state≠IDLE and state≠READY) or refresh_pending, so no request is accepted while a refresh is pending.
  - From IDLE or READY, a pending refresh enters REFRESH for REFRESH_CYCLES cycles, then clears pending and returns to IDLE.
  - A refresh expiring during WRITE/READ waits for that operation to finish. The READY pulse is still delivered, but busy=1 in that cycle.
  - Reset clears refresh_pending and the refresh counter.
- HOST_RESP_REFRESH_EN undefined: no refresh logic; busy depends only on WRITE/READ.

## Test plan
- Reset: hold rst=1 for 2 cycles with both enables high -> busy=0, rd_ready=0, rd_data=0 throughout; no acceptance until rst=0.
- Write then read: write 0xA5A5 to address 3 -> busy=1 for exactly 3 cycles. Then read address 3 -> busy=1 for 5 cycles, then one cycle with rd_ready=1, rd_data=0xA5A5, busy=0. rd_data stays 0xA5A5 afterwards.
- Collision and aliasing: assert wr_enable and rd_enable together, address 0x000015, data 0x1234 -> write performed, no rd_ready within 10 cycles. Then read address 0x5 -> rd_data=0x1234.
- Ignored request: write to address 1, then pulse rd_enable for one cycle during busy -> no rd_ready ever produced. Back-to-back reads with rd_enable held in the READY cycle -> second accepted in the READY cycle.
- Reset mid-read: accept a read of address 3, assert rst in cycle 2 -> rd_ready never pulses, busy=0 after reset. A following read of address 3 still returns 0xA5A5.
- Refresh (macro defined, PERIOD=16, CYCLES=4, idle): busy=1 for 4 cycles starting 16 cycles after reset release. A read held across the stall is accepted on the first busy=0 edge, and its rd_ready arrives 6 cycles after that edge.
